// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // Counter width for a given iteration count; also provided for the default configuration.
    function automatic int unsigned div_cnt_width(input int unsigned iters);
        return (iters < 1) ? 1 : $clog2(iters + 1);
    endfunction

    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo}, trial subtract, select.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;
    logic           w_take;

    // rem < divisor holds between steps, so the trial fits in WIDTH+1 signed bits.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, i_dvs};
    assign w_take  = ~w_trial[WIDTH];

    assign o_rem = w_take ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_take};

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider: sign handling, control FSM and result registers.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned      CNT_W    = div_cnt_width(ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dvd_raw;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic             w_accept;
    logic             w_last;

    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_LAST);

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // Sign correction wraps modulo 2^WIDTH, so MIN / -1 yields MIN without a flag.
    assign w_quo_fix = r_q_neg ? (~w_step_quo + 1'b1) : w_step_quo;
    assign w_rem_fix = r_r_neg ? (~w_step_rem + 1'b1) : w_step_rem;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN:  if (r_cnt == CNT_LAST) w_state_nxt = FIN;
            FIN:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_dvd_raw <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_dvd_mag;
            r_dvs     <= w_dvs_mag;
            r_dvd_raw <= dividend;
            r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg   <= w_dvd_neg;
            r_dbz     <= (divisor == '0);
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
        end
    end

    // Results are captured on the final iteration edge so they are valid throughout FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_last) begin
            r_quotient    <= r_dbz ? '1 : w_quo_fix;
            r_remainder   <= r_dbz ? r_dvd_raw : w_rem_fix;
            r_div_by_zero <= r_dbz;
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == FIN);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
